// File: rtl/iob_mem_rd_serializer.sv
// Read-side serializer: fetches wide RAM words and streams them out as narrow valid/ready chunks.
// Define IOB_RD_SER_MSB_FIRST_EN to emit the most significant chunk of each word first.
module iob_mem_rd_serializer #(
    parameter int MEM_DATA_W = 32,
    parameter int OUT_DATA_W = 8,
    parameter int ADDR_W     = 6,
    parameter int LEN_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_r_en,
    output logic [ADDR_W-1:0]     mem_r_addr,
    input  logic [MEM_DATA_W-1:0] mem_data_in,
    output logic [OUT_DATA_W-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int RATIO   = MEM_DATA_W / OUT_DATA_W;
    localparam int CHUNK_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     base_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      word_idx;
    logic [CHUNK_W-1:0]    chunk_idx;
    logic [MEM_DATA_W-1:0] shreg;
    logic                  hs;
    logic                  last_chunk;

    assign hs         = dout_valid & dout_ready;
    assign last_chunk = (chunk_idx == CHUNK_W'(RATIO - 1));

    // All outputs decode straight from registers so reset clears them asynchronously.
    assign busy       = (state == FETCH) || (state == WAIT) || (state == SEND);
    assign done       = (state == DONE);
    assign mem_r_en   = (state == FETCH);
    assign dout_valid = (state == SEND);
    assign mem_r_addr = base_q + word_idx[ADDR_W-1:0];

`ifdef IOB_RD_SER_MSB_FIRST_EN
    assign dout = shreg[MEM_DATA_W-1 -: OUT_DATA_W];
`else
    assign dout = shreg[OUT_DATA_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len != '0) ? FETCH : DONE;
            FETCH: state_nxt = WAIT;
            WAIT:  state_nxt = SEND;
            SEND:  if (hs && last_chunk)
                       state_nxt = (word_idx + LEN_W'(1) == len_q) ? DONE : FETCH;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            word_idx  <= '0;
            chunk_idx <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: if (start && len != '0) begin
                    base_q   <= base_addr;
                    len_q    <= len;
                    word_idx <= '0;
                end
                WAIT: begin
                    shreg     <= mem_data_in;
                    chunk_idx <= '0;
                end
                SEND: if (hs) begin
`ifdef IOB_RD_SER_MSB_FIRST_EN
                    shreg <= shreg << OUT_DATA_W;
`else
                    shreg <= shreg >> OUT_DATA_W;
`endif
                    chunk_idx <= chunk_idx + CHUNK_W'(1);
                    if (last_chunk) word_idx <= word_idx + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_mem_rd_serializer.sv
// Scoreboard bench for iob_mem_rd_serializer: a word/chunk model feeds queues, monitors pop and compare.
module tb_iob_mem_rd_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  len;
    logic        busy, done, mem_r_en, dout_valid, dout_ready;
    logic [5:0]  mem_r_addr;
    logic [31:0] mem_data_in;
    logic [7:0]  dout;

    iob_mem_rd_serializer #(.MEM_DATA_W(32), .OUT_DATA_W(8), .ADDR_W(6), .LEN_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
        .mem_data_in(mem_data_in), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [64];
    always @(posedge clk) if (mem_r_en) mem_data_in <= ram[mem_r_addr];

    int pass_cnt = 0, tot_cnt = 0;
    logic [7:0] exp_chunk[$];
    logic [5:0] exp_addr[$];
    bit rand_rdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: word w of a transfer lives at (base+w) mod 64; chunks peel off by byte position.
    task automatic push_model(input logic [5:0] b, input logic [6:0] l);
        for (int w = 0; w < int'(l); w++) begin
            logic [5:0] a;
            a = 6'((int'(b) + w) % 64);
            exp_addr.push_back(a);
            for (int k = 0; k < 4; k++) begin
`ifdef IOB_RD_SER_MSB_FIRST_EN
                exp_chunk.push_back(8'(ram[a] >> (8 * (3 - k))));
`else
                exp_chunk.push_back(8'(ram[a] >> (8 * k)));
`endif
            end
        end
    endtask

    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    int negcnt = 0, start_n = 0, last_hs = 0, done_cnt = 0;
    bit first_pend = 0, hs_seen = 0, prev_hold = 0;
    logic [7:0] prev_dout;

    always @(negedge clk) begin
        negcnt++;
        if (!rst_n) begin
            prev_hold  = 0;
            first_pend = 0;
        end else begin
            if (start && !busy && !done) begin
                start_n = negcnt; first_pend = 1; hs_seen = 0;
            end
            if (dout_valid && first_pend) begin
                chk("first_valid_latency", 64'(negcnt - start_n), 3);
                first_pend = 0;
            end
            if (prev_hold) begin
                chk("stall_valid_held", dout_valid, 1);
                chk("stall_dout_stable", dout, prev_dout);
            end
            prev_hold = dout_valid && !dout_ready;
            prev_dout = dout;
            if (dout_valid && dout_ready) begin
                if (exp_chunk.size() == 0) chk("unexpected_chunk", dout, 64'hFFFF_FFFF);
                else chk("chunk", dout, exp_chunk.pop_front());
                hs_seen = 1; last_hs = negcnt;
            end
            if (mem_r_en) begin
                if (exp_addr.size() == 0) chk("unexpected_read", mem_r_addr, 64'hFFFF_FFFF);
                else chk("read_addr", mem_r_addr, exp_addr.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (hs_seen) chk("done_latency", 64'(negcnt - last_hs), 1);
                else         chk("zero_len_done_latency", 64'(negcnt - start_n), 1);
            end
        end
    end

    task automatic wait_done(input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic pulse_start(input logic [5:0] b, input logic [6:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base_addr = '0; len = '0;
    endtask

    task automatic run(input logic [5:0] b, input logic [6:0] l, input bit pulse_busy);
        int d0;
        d0 = done_cnt;
        push_model(b, l);
        pulse_start(b, l);
        if (pulse_busy) begin
            repeat (2) @(posedge clk);
            pulse_start(b + 6'd5, 7'd3);
        end
        wait_done(600);
        @(negedge clk);
        chk("reads_outstanding", exp_addr.size(), 0);
        chk("chunks_outstanding", exp_chunk.size(), 0);
        chk("done_pulses", 64'(done_cnt - d0), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_r_en"}, mem_r_en, 0);
        chk({tag, "_mem_r_addr"}, mem_r_addr, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_dout"}, dout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, tot_cnt);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("por");
        rst_n = 1'b1;

        ram[4] = 32'hA1B2C3D4;
        run(6'd4, 7'd1, 0);

        ram[63] = 32'h11223344;
        ram[0]  = 32'h55667788;
        run(6'd63, 7'd2, 0);

        rand_rdy = 1;
        run(6'($urandom_range(0, 63)), 7'd2, 0);
        rand_rdy = 0;

        run(6'd9, 7'd0, 0);
        run(6'd20, 7'd2, 1);

        // Reset lands while the first word is being streamed under backpressure.
        rand_rdy = 1;
        push_model(6'd10, 7'd3);
        pulse_start(6'd10, 7'd3);
        for (int i = 0; i < 50 && !dout_valid; i++) @(negedge clk);
        chk("reached_send", dout_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        exp_addr.delete();
        exp_chunk.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(6'd10, 7'd3, 0);

        for (int t = 0; t < 6; t++) begin
            rand_rdy = t[0];
            run(6'($urandom_range(0, 63)), 7'($urandom_range(1, 4)), 0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
